// File: rtl/instr_encoder.sv
// instr_encoder: packs a decoded instruction description into an RV32I machine
// word and streams the words into an instruction-memory load port. Every word
// goes to the next sequential address. Malformed requests are consumed, dropped
// and flagged with a sticky error that keeps the first error code.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [3:0] {
    K_LW    = 4'd0,
    K_SW    = 4'd1,
    K_R     = 4'd2,
    K_BR    = 4'd3,
    K_IALU  = 4'd4,
    K_JAL   = 4'd5,
    K_AUIPC = 4'd6,
    K_LUI   = 4'd7,
    K_JALR  = 4'd8
  } kind_e;

  typedef enum logic [1:0] {
    E_NONE  = 2'b00,
    E_RANGE = 2'b01,
    E_ALIGN = 2'b10,
    E_KIND  = 2'b11
  } err_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  err_e              code;
  logic              fits_i;
  logic              fits_b;
  logic              fits_j;
  logic              fits_sh;
  logic              is_shift;
  logic              accept;
  logic              xfer;
  logic              last;

  assign in_ready = !full && (!out_valid || out_ready) && !start;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign last     = &ptr;

  // Signed range checks: the value fits when all bits above the field's sign bit
  // replicate it.
  always_comb begin
    fits_i   = (imm[31:11] == '0) || (imm[31:11] == '1);
    fits_b   = (imm[31:12] == '0) || (imm[31:12] == '1);
    fits_j   = (imm[31:20] == '0) || (imm[31:20] == '1);
    fits_sh  = (imm[31:5] == '0);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  end

  // Pack the request and classify it; unknown kind beats alignment beats range.
  always_comb begin
    word = '0;
    code = E_NONE;
    case (kind_e'(kind))
      K_LW: begin
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        if (!fits_i) code = E_RANGE;
      end
      K_SW: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        if (!fits_i) code = E_RANGE;
      end
      K_R: begin
        word = {funct7, rs2, rs1, funct3, rd, OP_R};
      end
      K_BR: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        if (imm[0])       code = E_ALIGN;
        else if (!fits_b) code = E_RANGE;
      end
      K_IALU: begin
        if (is_shift) begin
          word = {funct7, imm[4:0], rs1, funct3, rd, OP_IALU};
          if (!fits_sh) code = E_RANGE;
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OP_IALU};
          if (!fits_i) code = E_RANGE;
        end
      end
      K_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        if (imm[0])       code = E_ALIGN;
        else if (!fits_j) code = E_RANGE;
      end
      K_AUIPC: begin
        word = {imm[31:12], rd, OP_AUIPC};
        if (imm[11:0] != '0) code = E_RANGE;
      end
      K_LUI: begin
        word = {imm[31:12], rd, OP_LUI};
        if (imm[11:0] != '0) code = E_RANGE;
      end
      K_JALR: begin
        word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        if (!fits_i) code = E_RANGE;
      end
      default: code = E_KIND;
    endcase
  end

  // Output register, write pointer, counters and sticky error.
  // The pointer always equals out_addr of the word being presented, so a word
  // accepted during a transfer takes ptr+1. If that transfer is of the last
  // address the memory is now full and the newly accepted word is dropped.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      ptr       <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_NONE;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
        count     <= count + (ADDR_W+1)'(1);
        if (last) full <= 1'b1;
        else      ptr  <= ptr + ADDR_W'(1);
      end
      if (accept) begin
        if (code != E_NONE) begin
          err <= 1'b1;
          if (!err) err_code <= code;
        end else if (!(xfer && last)) begin
          out_valid <= 1'b1;
          out_instr <= word;
          out_addr  <= xfer ? ptr + ADDR_W'(1) : ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder with a 4-word memory. The reference model encodes
// with shifts and masks on integers, checks ranges with signed compares, and
// tracks the output stream at transaction level.
module tb_instr_encoder;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    kind = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          full;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  bit          mknown = 0;
  bit          mvalid, mfull, merr;
  int          mcode, mcount, mptr, maddr;
  logic [31:0] minstr;
  bit          acc_last = 0;

  int bnd [22] = '{0, 1, -1, 2, 3, 4, 31, 32, -2048, 2047, 2048, -2049,
                   -4096, 4094, 4096, -4098, 1048574, -1048576, 1048576,
                   -1048578, 4095, 'h12345000};

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .full(full), .err(err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // RV32I encoding from the field layout; c: 0 ok, 1 range, 2 alignment, 3 kind
  function automatic void ref_enc(input int k, input int d, input int s1, input int s2,
                                  input int f3, input int f7, input logic [31:0] u,
                                  output logic [31:0] w, output int c);
    longint v;
    v = longint'($signed(u));
    w = '0;
    c = 0;
    case (k)
      0, 8: begin
        w = ((u & 32'hFFF) << 20) | (s1 << 15) | ((k == 8 ? 0 : f3) << 12) | (d << 7)
            | (k == 8 ? 32'h67 : 32'h03);
        if (v < -2048 || v > 2047) c = 1;
      end
      1: begin
        w = (((u >> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
            | ((u & 31) << 7) | 32'h23;
        if (v < -2048 || v > 2047) c = 1;
      end
      2: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
      3: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15)
            | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
        if (v % 2 != 0) c = 2;
        else if (v < -4096 || v > 4094) c = 1;
      end
      4: begin
        if (f3 == 1 || f3 == 5) begin
          w = (f7 << 25) | ((u & 31) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
          if (v < 0 || v > 31) c = 1;
        end else begin
          w = ((u & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
          if (v < -2048 || v > 2047) c = 1;
        end
      end
      5: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 255) << 12) | (d << 7) | 32'h6F;
        if (v % 2 != 0) c = 2;
        else if (v < -1048576 || v > 1048574) c = 1;
      end
      6, 7: begin
        w = (u & 32'hFFFFF000) | (d << 7) | (k == 6 ? 32'h17 : 32'h37);
        if (u % 4096 != 0) c = 1;
      end
      default: c = 3;
    endcase
  endfunction

  task automatic mclear();
    mvalid = 0; mfull = 0; merr = 0; mcode = 0; mcount = 0;
    mptr = 0; maddr = 0; minstr = '0;
  endtask

  // compare DUT against the model, then advance the model by one clock
  task automatic model_step();
    bit exp_ready, xfer, acc;
    logic [31:0] w;
    int c;
    exp_ready = !mfull && (!mvalid || out_ready) && !start;
    if (mknown) begin
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      chk("out_instr", out_instr, minstr);
      chk("out_addr", 32'(out_addr), 32'(maddr));
      chk("full", 32'(full), 32'(mfull));
      chk("err", 32'(err), 32'(merr));
      chk("err_code", 32'(err_code), 32'(mcode));
      chk("count", 32'(count), 32'(mcount));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
    end
    acc_last = 0;
    if (reset) begin
      mclear();
      mknown = 1;
    end else if (mknown) begin
      if (start) mclear();
      else begin
        xfer = mvalid && out_ready;
        acc  = in_valid && exp_ready;
        acc_last = acc;
        if (xfer) begin
          mvalid = 0;
          mcount++;
          if (mptr == CAP - 1) mfull = 1;
          else mptr++;
        end
        if (acc) begin
          ref_enc(int'(kind), int'(rd), int'(rs1), int'(rs2), int'(funct3), int'(funct7),
                  imm, w, c);
          if (c != 0) begin
            if (!merr) mcode = c;
            merr = 1;
          end else if (!mfull) begin
            mvalid = 1;
            minstr = w;
            maddr  = mptr;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input int d, input int s1, input int s2,
                     input int f3, input int f7, input logic [31:0] im);
    in_valid = 1'b1;
    kind = 4'(k); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    funct3 = 3'(f3); funct7 = 7'(f7); imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = 32'(bnd[$urandom_range(0, 21)]);
      1: r = 32'($signed(12'($urandom)));
      2: r = $urandom;
      3: r = $urandom & 32'hFFFFF000;
      default: r = 32'($signed(13'($urandom))) & ~32'd1;
    endcase
    return r;
  endfunction

  initial begin
    // reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // basic back-to-back encodes, then capacity reached at 4 words
    out_ready = 1'b1;
    req(4, 1, 0, 0, 0, 0, 32'd5); cyc();
    chk("addi", out_instr, 32'h00500093);
    chk("addi_addr", 32'(out_addr), 32'd0);
    req(0, 2, 1, 0, 2, 0, 32'd8); cyc();
    chk("lw", out_instr, 32'h0080A103);
    chk("lw_addr", 32'(out_addr), 32'd1);
    req(1, 0, 1, 2, 2, 0, 32'd4); cyc();
    chk("sw", out_instr, 32'h0020A223);
    chk("sw_addr", 32'(out_addr), 32'd2);
    req(2, 3, 1, 2, 0, 0, 32'd0); cyc();
    chk("add", out_instr, 32'h002081B3);
    chk("add_addr", 32'(out_addr), 32'd3);
    idle(); cyc();
    chk("basic_count", 32'(count), 32'd4);
    chk("cap_full", 32'(full), 32'd1);
    chk("cap_in_ready", 32'(in_ready), 32'd0);
    req(4, 1, 0, 0, 0, 0, 32'd7); cyc();
    chk("cap_no_emit", 32'(out_valid), 32'd0);
    idle(); start = 1'b1; cyc(); start = 1'b0;
    chk("start_full", 32'(full), 32'd0);
    chk("start_count", 32'(count), 32'd0);

    // control flow / upper immediates, restarting at address 0
    req(3, 0, 1, 2, 0, 0, -32'sd4); cyc();
    chk("beq", out_instr, 32'hFE208EE3);
    chk("beq_addr", 32'(out_addr), 32'd0);
    req(5, 1, 0, 0, 0, 0, 32'd8); cyc();
    chk("jal", out_instr, 32'h008000EF);
    req(7, 5, 0, 0, 0, 0, 32'h12345000); cyc();
    chk("lui", out_instr, 32'h123452B7);
    idle(); cyc();
    chk("cf_count", 32'(count), 32'd3);

    // errors
    start = 1'b1; cyc(); start = 1'b0;
    req(3, 0, 1, 2, 0, 0, 32'd3); cyc();
    chk("misalign_err", 32'(err), 32'd1);
    chk("misalign_code", 32'(err_code), 32'd2);
    chk("misalign_no_emit", 32'(out_valid), 32'd0);
    chk("misalign_count", 32'(count), 32'd0);
    req(4, 1, 0, 0, 0, 0, 32'd4096); cyc();
    chk("first_code_kept", 32'(err_code), 32'd2);
    idle(); start = 1'b1; cyc(); start = 1'b0;
    chk("start_err", 32'(err), 32'd0);
    req(12, 1, 0, 0, 0, 0, 32'd0); cyc();
    chk("unknown_code", 32'(err_code), 32'd3);
    idle(); start = 1'b1; cyc(); start = 1'b0;

    // backpressure: held word stays stable, then reload with no bubble
    out_ready = 1'b0;
    req(4, 1, 0, 0, 0, 0, 32'd1); cyc();
    chk("bp_valid", 32'(out_valid), 32'd1);
    req(4, 2, 0, 0, 0, 0, 32'd2);
    repeat (4) begin
      cyc();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_instr", out_instr, 32'h00100093);
      chk("bp_addr", 32'(out_addr), 32'd0);
    end
    out_ready = 1'b1; cyc();
    chk("bp_next_instr", out_instr, 32'h00200113);
    chk("bp_next_addr", 32'(out_addr), 32'd1);
    chk("bp_count1", 32'(count), 32'd1);
    idle(); cyc();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // reset while a word is held
    start = 1'b1; cyc(); start = 1'b0;
    out_ready = 1'b0;
    req(0, 4, 3, 0, 2, 0, 32'd16); cyc();
    chk("mid_valid", 32'(out_valid), 32'd1);
    idle(); reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    out_ready = 1'b1; cyc();
    chk("mid_discarded", 32'(count), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 3) != 0);
        kind = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        imm = rnd_imm();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      start = (mfull && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 59) == 0)
              || (merr && ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    start = 1'b0; reset = 1'b0; idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
